// File: rtl/vacc_bram.sv
// Element-wise accumulator of acc_len vectors with running sums in a BRAM delay line; dump 1 cycle after vector 0 input, no backpressure.
// Optional VACC_SAT_EN makes the adder saturate on signed overflow instead of wrapping.
module bram_delay_behave #(
    parameter int DELAY   = 7,
    parameter int LATENCY = 2,
    parameter int WIDTH   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    localparam int DEPTH = DELAY - LATENCY;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem  [DEPTH];
    logic [WIDTH-1:0] pipe [LATENCY];
    logic [AW-1:0]    ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else begin
            ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
        end
    end

    // Read-before-write on the same address gives DEPTH cycles, the pipe adds LATENCY.
    always_ff @(posedge clk) begin
        mem[ptr] <= din;
        pipe[0]  <= mem[ptr];
        for (int i = 1; i < LATENCY; i++) begin
            pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[LATENCY-1];
endmodule

module vacc_bram #(
    parameter int WIDTH_IN     = 18,
    parameter int WIDTH_OUT    = 32,
    parameter int VEC_LEN      = 1024,
    parameter int ACC_LEN_BITS = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ce,
    input  logic                    sync_in,
    input  logic [ACC_LEN_BITS-1:0] acc_len,
    input  logic [WIDTH_IN-1:0]     din,
    output logic [WIDTH_OUT-1:0]    dout,
    output logic                    dout_valid,
    output logic                    sync_out
);
    localparam int SW = $clog2(VEC_LEN);

    typedef enum logic {IDLE, ACC} state_t;

    state_t                  state;
    logic [SW-1:0]           samp_cnt;
    logic [ACC_LEN_BITS-1:0] vec_cnt;
    logic [ACC_LEN_BITS-1:0] acc_len_q;
    logic [ACC_LEN_BITS-1:0] acc_len_eff;
    logic                    full_q;
    logic                    samp_wrap;
    logic                    vec_wrap;
    logic signed [WIDTH_OUT-1:0] din_ext;
    logic signed [WIDTH_OUT-1:0] fb;
    logic signed [WIDTH_OUT-1:0] add_raw;
    logic signed [WIDTH_OUT-1:0] add_res;
    logic signed [WIDTH_OUT-1:0] sum_q;
    logic                    unused_ce;

    assign unused_ce   = ce;
    assign acc_len_eff = (acc_len == '0) ? ACC_LEN_BITS'(1) : acc_len;
    assign samp_wrap   = (samp_cnt == SW'(VEC_LEN - 1));
    assign vec_wrap    = samp_wrap && (vec_cnt == acc_len_q - 1'b1);
    assign din_ext     = WIDTH_OUT'($signed(din));
    assign add_raw     = fb + din_ext;

`ifdef VACC_SAT_EN
    logic ovf;
    assign ovf     = (fb[WIDTH_OUT-1] == din_ext[WIDTH_OUT-1]) &&
                     (add_raw[WIDTH_OUT-1] != fb[WIDTH_OUT-1]);
    assign add_res = !ovf ? add_raw :
                     fb[WIDTH_OUT-1] ? {1'b1, {(WIDTH_OUT-1){1'b0}}}
                                     : {1'b0, {(WIDTH_OUT-1){1'b1}}};
`else
    assign add_res = add_raw;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            samp_cnt   <= '0;
            vec_cnt    <= '0;
            acc_len_q  <= ACC_LEN_BITS'(1);
            full_q     <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            sync_out   <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            sync_out   <= 1'b0;
            case (state)
                IDLE: begin
                    if (sync_in) begin
                        state     <= ACC;
                        samp_cnt  <= '0;
                        vec_cnt   <= '0;
                        acc_len_q <= acc_len_eff;
                        full_q    <= 1'b0;
                    end
                end
                ACC: begin
                    // fb carries the final sums of the previous accumulation while vector 0 streams in.
                    if (vec_cnt == '0 && full_q) begin
                        dout       <= fb;
                        dout_valid <= 1'b1;
                    end
                    if (sync_in) begin
                        samp_cnt  <= '0;
                        vec_cnt   <= '0;
                        acc_len_q <= acc_len_eff;
                        full_q    <= 1'b0;
                    end else begin
                        samp_cnt <= samp_wrap ? '0 : samp_cnt + 1'b1;
                        if (vec_wrap) begin
                            vec_cnt   <= '0;
                            acc_len_q <= acc_len_eff;
                            full_q    <= 1'b1;
                            sync_out  <= 1'b1;
                        end else if (samp_wrap) begin
                            vec_cnt <= vec_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Loading din on vector 0 discards stale delay-line contents, so the RAM needs no clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= (vec_cnt == '0) ? din_ext : add_res;
        end
    end

    bram_delay_behave #(
        .DELAY   (VEC_LEN - 1),
        .LATENCY (2),
        .WIDTH   (WIDTH_OUT)
    ) u_fb (
        .clk  (clk),
        .rst  (rst),
        .din  (sum_q),
        .dout (fb)
    );
endmodule

// File: tb/tb_vacc_bram.sv
// Directed and random stimulus for vacc_bram against an array-based accumulation model.
module tb_vacc_bram;
    localparam int VL = 8;

    logic        clk;
    logic        rst;
    logic        ce;
    logic        sync_in;
    logic [15:0] acc_len;
    logic [17:0] din;
    logic [19:0] dout;
    logic        dout_valid;
    logic        sync_out;

    int errors = 0;
    int checks = 0;

    // Reference model: per-index sums of the current accumulation and the last completed one.
    bit     m_active;
    bit     m_have;
    int     m_k;
    int     m_v;
    int     m_alen;
    longint m_acc  [VL];
    longint m_done [VL];
    longint e_dout;
    bit     e_valid;
    bit     e_sync;

    vacc_bram #(
        .WIDTH_IN     (18),
        .WIDTH_OUT    (20),
        .VEC_LEN      (VL),
        .ACC_LEN_BITS (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .sync_in    (sync_in),
        .acc_len    (acc_len),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .sync_out   (sync_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic longint fix(input longint x);
`ifdef VACC_SAT_EN
        if (x > 524287) return 524287;
        if (x < -524288) return -524288;
        return x;
`else
        longint y;
        y = x & 64'hFFFFF;
        if (y >= 524288) y = y - 1048576;
        return y;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_have   = 0;
        e_dout   = 0;
        e_valid  = 0;
        e_sync   = 0;
    endtask

    task automatic model_edge(input bit s, input int al, input longint d);
        e_valid = 0;
        e_sync  = 0;
        if (!m_active) begin
            if (s) begin
                m_active = 1; m_k = 0; m_v = 0; m_have = 0;
                m_alen = (al == 0) ? 1 : al;
            end
            return;
        end
        if (m_have && m_v == 0) begin
            e_dout  = m_done[m_k];
            e_valid = 1;
        end
        if (s) begin
            m_k = 0; m_v = 0; m_have = 0;
            m_alen = (al == 0) ? 1 : al;
            return;
        end
        m_acc[m_k] = (m_v == 0) ? d : fix(m_acc[m_k] + d);
        if (m_k == VL - 1 && m_v == m_alen - 1) begin
            m_done = m_acc;
            m_have = 1;
            e_sync = 1;
        end
        m_k++;
        if (m_k == VL) begin
            m_k = 0;
            m_v++;
            if (m_v == m_alen) begin
                m_v = 0;
                m_alen = (al == 0) ? 1 : al;
            end
        end
    endtask

    task automatic check_outputs();
        logic [19:0] e20;
        e20 = e_dout[19:0];
        chk("dout_valid", {31'b0, dout_valid}, {31'b0, e_valid});
        chk("sync_out", {31'b0, sync_out}, {31'b0, e_sync});
        chk("dout", {12'b0, dout}, {12'b0, e20});
    endtask

    task automatic step(input bit s, input int al, input logic [17:0] d);
        sync_in = s;
        acc_len = 16'(al);
        din     = d;
        @(posedge clk);
        model_edge(s, al, longint'($signed(d)));
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        sync_in = 1'b0;
        rst = 1'b1;
        #2;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_outputs();
    endtask

    initial begin
        int first_i;
        int nv;
        logic [17:0] dd;
        logic [19:0] hist [40];
        logic [19:0] ov_exp;

        rst = 1'b1; ce = 1'b1; sync_in = 1'b0; acc_len = '0; din = '0;
        do_reset();

        // Constant input, acc_len 4.
        step(1, 4, 18'd0);
        first_i = -1;
        for (int i = 0; i < 100; i++) begin
            step(0, 4, 18'd1);
            if (dout_valid && first_i < 0) begin
                first_i = i;
                chk("const_first_value", {12'b0, dout}, 32'd4);
            end
        end
        chk("const_first_dump_cycle", 32'(first_i), 32'd32);

        // Ramp input, acc_len 3.
        step(1, 3, 18'd0);
        nv = 0;
        for (int i = 0; i < 96; i++) begin
            step(0, 3, 18'(i % VL));
            if (dout_valid) begin
                chk("ramp_value", {12'b0, dout}, 32'(3 * (nv % VL)));
                nv++;
            end
        end
        chk("ramp_valid_count", 32'(nv), 32'd24);

        // acc_len 0 behaves as 1: pure 9-cycle delay.
        step(1, 0, 18'd0);
        for (int i = 0; i < 40; i++) begin
            dd = 18'($urandom);
            hist[i] = 20'($signed(dd));
            step(0, 0, dd);
            if (i >= VL) begin
                chk("zero_len_delay", {12'b0, dout}, {12'b0, hist[i-VL]});
                chk("zero_len_valid", {31'b0, dout_valid}, 32'd1);
            end
        end

        // Resync after 2 of 4 vectors discards the partial sums.
        step(1, 4, 18'd1);
        for (int i = 0; i < 2 * VL; i++) step(0, 4, 18'd1);
        step(1, 4, 18'd1);
        first_i = -1;
        for (int i = 0; i < 40; i++) begin
            step(0, 4, 18'd1);
            if (dout_valid && first_i < 0) begin
                first_i = i;
                chk("resync_value", {12'b0, dout}, 32'd4);
            end
        end
        chk("resync_first_dump_cycle", 32'(first_i), 32'd32);

        // Overflow of a 20-bit accumulator, then reset in the middle of the dump.
`ifdef VACC_SAT_EN
        ov_exp = 20'h7FFFF;
`else
        ov_exp = 20'hFFFF0;
`endif
        step(1, 16, 18'd131071);
        first_i = -1;
        for (int i = 0; i < 16 * VL + 3; i++) begin
            step(0, 16, 18'd131071);
            if (dout_valid && first_i < 0) begin
                first_i = i;
                chk("overflow_value", {12'b0, dout}, {12'b0, ov_exp});
            end
        end
        chk("overflow_first_dump_cycle", 32'(first_i), 32'(16 * VL));
        do_reset();
        for (int i = 0; i < 3 * VL; i++) step(0, 2, 18'($urandom));

        // Random data, acc_len and occasional resyncs.
        step(1, 2, 18'($urandom));
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 59) == 0), int'($urandom_range(0, 3)), 18'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vacc_bram.md
# vacc_bram

Vector accumulator for streaming spectra: sums `acc_len` consecutive vectors of `VEC_LEN` samples element-wise and dumps each completed sum vector once. It sits directly downstream of the FFT/PFB datapath. Its feedback path is a `bram_delay_behave` instance, so the running sums live in block RAM rather than registers.

## Interface
- `WIDTH_IN`, default 18: signed input sample width.
- `WIDTH_OUT`, default 32: signed accumulator and output width; must be ≥ `WIDTH_IN`.
- `VEC_LEN`, default 1024: samples per vector; must be ≥ 6.
- `ACC_LEN_BITS`, default 16: width of `acc_len`.
- `clk`, input, 1: clock; all logic is on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `ce`, input, 1: clock enable for Simulink compatibility only; unused and must be tied high.
- `sync_in`, input, 1: frame sync; the `din` in the cycle after `sync_in` is sample 0 of vector 0.
- `acc_len`, input, `ACC_LEN_BITS`: vectors per accumulation; latched at each accumulation start; 0 is treated as 1.
- `din`, input, `WIDTH_IN`: signed sample, one per cycle, continuous.
- `dout`, output, `WIDTH_OUT`: accumulated sample.
- `dout_valid`, output, 1: `dout` holds a completed sum.
- `sync_out`, output, 1: one-cycle pulse, asserted in the cycle before the first `dout_valid` of each dump.

## Operation
- **State machine**
  - IDLE after reset: counters held at 0, all outputs 0.
  - `sync_in` moves IDLE → ACC. Sample 0 of vector 0 is the next cycle's `din`.
- **Counters**
  - `samp_cnt` runs 0..`VEC_LEN`-1 and wraps.
  - `vec_cnt` runs 0..`acc_len_q`-1 and increments on `samp_cnt` wrap.
  - On `vec_cnt` wrap, `acc_len_q` reloads from `acc_len`.
- **Feedback loop**
  - The sum register is followed by `bram_delay_behave` with DELAY=`VEC_LEN`-1, LATENCY=2, WIDTH=`WIDTH_OUT`.
  - Total loop length is exactly `VEC_LEN` cycles, so `fb` in a given cycle is the sum for the same sample index one vector earlier.
- **Sum update**
  - When `vec_cnt`==0, the sum register loads sign-extended `din` (first-vector zeroing).
  - Otherwise it loads `fb` + sign-extended `din`.
  - Delay-line contents are therefore never required to be reset.
- **Dump**
  - During `vec_cnt`==0 of every accumulation after a complete one, `dout` <= `fb` and `dout_valid` <= 1 for all `VEC_LEN` samples.
  - Otherwise `dout_valid` <= 0 and `dout` holds its value.
- **`full_q` flag**
  - Set when `vec_cnt` wraps at the end of an uninterrupted accumulation.
  - Cleared by reset and by `sync_in`.
  - A dump occurs only while `full_q`=1.
- **`sync_in` while in ACC**
  - Restarts both counters on the next sample.
  - Clears `full_q`, so the partial accumulation is discarded and no dump of it occurs.
  - Re-latches `acc_len`.
- **Arithmetic**: two's complement, wrapping modulo 2^`WIDTH_OUT` (see Configuration).

## Timing
- **Latency**: `dout` for sample k appears 1 cycle after `din` sample k of the next accumulation's vector 0. That is `VEC_LEN`+1 cycles after the last contributing input.
- **Dump cadence**: one dump of `VEC_LEN` consecutive valid cycles every `acc_len_q`·`VEC_LEN` cycles.
- **Reset values**: `dout`=0, `dout_valid`=0, `sync_out`=0.
  - Asserting `rst` mid-dump forces these values immediately.
  - After release the block stays in IDLE until `sync_in`.
- **`sync_in` on the same cycle as a `samp_cnt`/`vec_cnt` wrap**: `sync_in` wins, the counters restart, and no dump follows.
- **`acc_len` changes mid-accumulation**: no effect until the next reload.

## Configuration
- `VACC_SAT_EN`
  - Defined: the adder saturates to +2^(`WIDTH_OUT`-1)-1 or -2^(`WIDTH_OUT`-1) on signed overflow.
  - Undefined: the adder wraps.
- Latency and all other behaviour are identical either way.

## Test plan
- **Constant input**: `VEC_LEN`=8, `acc_len`=4, `din`=1, one `sync_in`.
  - Expected: first dump begins 33 cycles after the first sample; eight outputs of 4; `dout_valid` high for 8 cycles every 32 cycles; `sync_out` one cycle before each dump.
- **Ramp input**: `din`=`samp_cnt`, `acc_len`=3.
  - Expected: `dout` sequence 0,3,6,…,21 on every dump.
- **Zero `acc_len`**: `acc_len`=0.
  - Expected: behaves as 1; `dout` equals `din` delayed 9 cycles, with `dout_valid` continuous after the first vector.
- **Mid-accumulation sync**: second `sync_in` after 2 of 4 vectors.
  - Expected: no dump of the partial sums; next dump exactly 33 cycles after the new first sample, with values 4.
- **Overflow**: `WIDTH_IN`=18, `WIDTH_OUT`=20, `din`=131071, `acc_len`=16.
  - Expected: `dout`=-16 without `VACC_SAT_EN`, 524287 with it.
- **Reset mid-dump**: `rst` pulsed during a dump.
  - Expected: `dout`, `dout_valid` and `sync_out` go to 0 immediately; no output until `sync_in` plus one full accumulation.
